orb_uart_pkt_rx: RTL and testbench
==================================

# orb_uart_pkt_rx

Receive-side packet framer for the Orbita M16 telemetry path. It samples the RS-485 `UART_RX` line (8N1, LSB first, ~2.38 Mbaud), validates start and stop bits, and assembles one fixed-length packet per request. Each received byte is written into the downstream frame buffer as a write strobe with an address. The packet-valid pulse (`ValRX` at top level) tells the M16 frame builder that a complete, error-free packet has been stored.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 34: clk80MHz cycles per UART bit (420 ns bit time, 1.2 % error).
- `PKT_LEN`, default 20: bytes per packet.
- `TIMEOUT_CLKS`, default 1360: idle clocks (40 bit times) allowed before a start edge.

Ports:
- `clk80MHz` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-low.
- `arm` in 1: one-cycle pulse that starts packet reception.
- `UART_RX` in 1: asynchronous serial line; idles high.
- `wr_en` out 1: one-cycle byte write strobe.
- `wr_addr` out $clog2(PKT_LEN): byte index within the packet, 0..PKT_LEN-1.
- `wr_data` out 8: received byte.
- `pkt_valid` out 1: one-cycle pulse when a full packet has been stored.
- `busy` out 1: high from `arm` until the packet completes or aborts.
- `frame_err` out 1: sticky flag for a bad stop bit; cleared by `arm`.
- `timeout` out 1: one-cycle pulse when the wait for a start edge expires.
- `byte_cnt` out $clog2(PKT_LEN+1): bytes accepted in the current or last packet.

## Operation
- `UART_RX` passes through a two-flop synchronizer before any use. It is held at 1 during reset.
- State machine: IDLE, WAIT_START, START, DATA, STOP, DONE.
- **IDLE**
  - On `arm`: clear `byte_cnt`, `frame_err` and the timeout counter, then go to WAIT_START.
- **WAIT_START**
  - A falling edge on the synchronized RX goes to START and resets the bit counter.
  - The timeout counter increments every clock. When it reaches TIMEOUT_CLKS-1: pulse `timeout` and go to IDLE. `byte_cnt` keeps its value.
- **START**
  - Sample at count CLKS_PER_BIT/2 (mid-bit).
  - Line still low: go to DATA with the bit counter reset. Line high (glitch): return to WAIT_START without clearing the timeout counter.
- **DATA**
  - Sample every CLKS_PER_BIT clocks, shifting into bit[7] so the first received bit ends up at bit 0.
  - After 8 samples, go to STOP.
- **STOP**
  - Sample at mid-bit.
  - High: register the byte, pulse `wr_en` with `wr_addr` = `byte_cnt`, increment `byte_cnt` and clear the timeout counter.
    - If `byte_cnt` now equals PKT_LEN, go to DONE; otherwise go to WAIT_START.
  - Low: set `frame_err`, issue no write and go to IDLE. The packet is aborted and `pkt_valid` is never raised.
- **DONE**
  - Pulse `pkt_valid` for one cycle, then go to IDLE.
- `arm` in any non-IDLE state restarts the packet: counters cleared, state WAIT_START, any partial byte discarded. `arm` takes priority over every other transition in the same cycle.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - all outputs 0, state IDLE, shift register 0;
  - synchronizer flops 1.
- Input latency is 2 clocks of synchronizer delay on every sampled edge.
- `wr_en` is asserted on the clock after the mid-stop-bit sample. `wr_addr`/`wr_data` are valid in the same cycle and held until the next write.
- `pkt_valid` follows the last `wr_en` by exactly 1 clock. `busy` falls in the same cycle `pkt_valid` is high.
- `timeout` and `pkt_valid` are mutually exclusive. At most one of `wr_en`, `pkt_valid`, `timeout` is high in any cycle.
- Reset mid-byte: immediate return to the reset state. There is no write of the partial byte.

## Structure
- Shared package `orb_uart_pkg` holds:
  - the state enum;
  - `ORB_CLKS_PER_BIT` = 34;
  - `ORB_PKT_LEN` = 20.
- The top-level builder imports the package for `PKT_LEN`-derived buffer widths.
- One sub-module: `orb_uart_byte_rx`, the synchronizer plus START/DATA/STOP bit engine.
  - Outputs: `byte_done`, `byte`, `stop_err`, `searching`.
  - The framer keeps the packet counter, timeout counter and DONE handling.

## Test plan
- **Full packet:** `arm`, then send 20 bytes 0x00,0x0A,…,0xBE, with 30 idle bit times before the first and 10 between bytes.
  - Expect 20 `wr_en` pulses, addr 0..19, data as sent.
  - Expect `pkt_valid` once, 1 clock after the last write, then `busy`=0 and `byte_cnt`=20.
- **Start glitch:** after `arm`, RX low for 8 clocks then high.
  - Expect no `wr_en` and the block still WAIT_START.
  - A following valid byte 0x5A is written at addr 0.
- **Frame error:** byte 5 sent with stop bit low.
  - Expect `frame_err`=1, writes only at addr 0..4, no `pkt_valid`, `busy`=0.
  - The next `arm` clears `frame_err`.
- **Timeout:** `arm`, 7 bytes, then RX idle.
  - Expect `timeout` pulse TIMEOUT_CLKS clocks after the 7th stop-sample, `byte_cnt`=7, no `pkt_valid`.
- **Re-arm:** `arm` during byte 12 of a packet.
  - The partial byte is dropped and the next byte is written at addr 0.
- **Reset:** `rst` low mid-DATA.
  - All outputs 0 immediately.
  - After release, `arm` followed by 20 bytes yields a normal `pkt_valid`.

Source files
------------

// File: rtl/orb_uart_pkg.sv
// Shared state encoding and default geometry for the Orbita M16 UART packet receiver.
package orb_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
    STOP,
    DONE
  } orb_uart_state_e;

  localparam int ORB_CLKS_PER_BIT = 34;
  localparam int ORB_PKT_LEN      = 20;
  localparam int ORB_TIMEOUT_CLKS = 1360;

endpackage

// File: rtl/orb_uart_byte_rx.sv
// RX synchronizer and 8N1 bit engine: finds a start edge, samples mid-bit, checks the stop bit.
//   state      | meaning
//   IDLE       | disabled, framer not receiving
//   WAIT_START | hunting for a falling edge on the synchronized line
//   START      | counting to mid start bit to reject glitches
//   DATA       | sampling 8 data bits, LSB first
//   STOP       | sampling the stop bit
module orb_uart_byte_rx
  import orb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = ORB_CLKS_PER_BIT
) (
  input  logic       clk80MHz,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       rx_i,
  output logic       byte_done_o,
  output logic [7:0] byte_o,
  output logic       stop_err_o,
  output logic       searching_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  orb_uart_state_e state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            fall;

  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign fall        = rx_prev_q & ~rx_sync_q;
  assign byte_o      = shift_q;
  assign searching_o = (state_q == WAIT_START);

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_o = 1'b0;
    stop_err_o  = 1'b0;
    if (clr_i) begin
      // re-arm discards whatever byte was in flight
      state_d   = WAIT_START;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (!en_i) begin
      state_d   = IDLE;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        WAIT_START: begin
          if (fall) begin
            state_d   = START;
            clk_cnt_d = '0;
          end
        end
        START: begin
          if (clk_cnt_q == HALF) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = rx_sync_q ? WAIT_START : DATA;
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_q == LAST) begin
            clk_cnt_d = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt_q == LAST) begin
            clk_cnt_d = '0;
            if (rx_sync_q) begin
              byte_done_o = 1'b1;
              state_d     = WAIT_START;
            end else begin
              stop_err_o = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/orb_uart_pkt_rx.sv
// Packet framer: counts bytes from the bit engine into the frame buffer and flags completion.
//   state      | meaning
//   IDLE       | not armed
//   WAIT_START | packet in progress (bit engine active, timeout runs while it hunts)
//   DONE       | last byte written, pkt_valid issued next
module orb_uart_pkt_rx
  import orb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = ORB_CLKS_PER_BIT,
  parameter int PKT_LEN      = ORB_PKT_LEN,
  parameter int TIMEOUT_CLKS = ORB_TIMEOUT_CLKS
) (
  input  logic                         clk80MHz,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         UART_RX,
  output logic                         wr_en,
  output logic [$clog2(PKT_LEN)-1:0]   wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         pkt_valid,
  output logic                         busy,
  output logic                         frame_err,
  output logic                         timeout,
  output logic [$clog2(PKT_LEN+1)-1:0] byte_cnt
);

  localparam int AW = $clog2(PKT_LEN);
  localparam int CW = $clog2(PKT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  orb_uart_state_e state_q, state_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            timeout_q, timeout_d;
  logic            frame_err_q, frame_err_d;
  logic            eng_done, eng_err, eng_search;
  logic [7:0]      eng_byte;

  orb_uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk80MHz   (clk80MHz),
    .rst        (rst),
    .en_i       (state_q == WAIT_START),
    .clr_i      (arm),
    .rx_i       (UART_RX),
    .byte_done_o(eng_done),
    .byte_o     (eng_byte),
    .stop_err_o (eng_err),
    .searching_o(eng_search)
  );

  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      pkt_valid_q <= pkt_valid_d;
      timeout_q   <= timeout_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    pkt_valid_d = 1'b0;
    timeout_d   = 1'b0;
    frame_err_d = frame_err_q;
    if (arm) begin
      state_d     = WAIT_START;
      byte_cnt_d  = '0;
      tmo_cnt_d   = '0;
      frame_err_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_START: begin
          if (eng_done) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = AW'(byte_cnt_q);
            wr_data_d  = eng_byte;
            byte_cnt_d = byte_cnt_q + 1'b1;
            tmo_cnt_d  = '0;
            if (byte_cnt_q == CW'(PKT_LEN - 1)) state_d = DONE;
          end else if (eng_err) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (eng_search) begin
            // timer pauses while a byte is being shifted in
            if (tmo_cnt_q == TW'(TIMEOUT_CLKS - 1)) begin
              timeout_d = 1'b1;
              state_d   = IDLE;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          pkt_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign pkt_valid = pkt_valid_q;
  assign timeout   = timeout_q;
  assign frame_err = frame_err_q;
  assign byte_cnt  = byte_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_orb_uart_pkt_rx.sv
// Scoreboard bench for orb_uart_pkt_rx: stimulus queues expected writes/pulses, a monitor checks them.
`timescale 1ns/1ps
module tb_orb_uart_pkt_rx;

  localparam int CPB     = 34;
  localparam int PKT_LEN = 20;
  localparam int TMO     = 1360;
  localparam int AW      = $clog2(PKT_LEN);
  localparam int CW      = $clog2(PKT_LEN + 1);

  logic          clk80MHz = 1'b0;
  logic          rst      = 1'b1;
  logic          arm      = 1'b0;
  logic          UART_RX  = 1'b1;
  logic          wr_en, pkt_valid, busy, frame_err, timeout;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [CW-1:0] byte_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          exp_pkt = 0;
  int          exp_tmo = 0;
  int          exp_tmo_bytes = 0;
  longint      cyc = 0;
  longint      last_wr = 0;

  always #6.25 clk80MHz = ~clk80MHz;

  orb_uart_pkt_rx #(
    .CLKS_PER_BIT(CPB),
    .PKT_LEN     (PKT_LEN),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk80MHz (clk80MHz),
    .rst      (rst),
    .arm      (arm),
    .UART_RX  (UART_RX),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pkt_valid(pkt_valid),
    .busy     (busy),
    .frame_err(frame_err),
    .timeout  (timeout),
    .byte_cnt (byte_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk80MHz) begin
    logic [15:0] e;
    cyc++;
    if (wr_en | pkt_valid | timeout)
      chk("one_hot_pulses", int'(wr_en) + int'(pkt_valid) + int'(timeout), 1);
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%02h, none expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", longint'(wr_addr), longint'(e[15:8]));
        chk("wr_data", longint'(wr_data), longint'(e[7:0]));
      end
      last_wr = cyc;
    end
    if (pkt_valid) begin
      if (exp_pkt == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt_valid: byte_cnt=%0d, none expected", byte_cnt);
      end else begin
        exp_pkt--;
        chk("pkt_valid_gap", cyc - last_wr, 1);
        chk("pkt_valid_busy", longint'(busy), 0);
        chk("pkt_valid_cnt", longint'(byte_cnt), PKT_LEN);
      end
    end
    if (timeout) begin
      if (exp_tmo == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_timeout: byte_cnt=%0d, none expected", byte_cnt);
      end else begin
        exp_tmo--;
        chk("timeout_delay", cyc - last_wr, TMO);
        chk("timeout_cnt", longint'(byte_cnt), exp_tmo_bytes);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk80MHz);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic expect_wr(input int addr, input logic [7:0] d);
    exp_q.push_back({8'(addr), d});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input int idle_bits);
    UART_RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      tick(CPB);
    end
    UART_RX = stop_b;
    tick(CPB);
    UART_RX = 1'b1;
    tick(CPB * idle_bits);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_pkt != 0 || exp_tmo != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_drained"}, exp_q.size() + exp_pkt + exp_tmo, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wr_en"}, longint'(wr_en), 0);
    chk({name, "_wr_addr"}, longint'(wr_addr), 0);
    chk({name, "_wr_data"}, longint'(wr_data), 0);
    chk({name, "_pkt_valid"}, longint'(pkt_valid), 0);
    chk({name, "_busy"}, longint'(busy), 0);
    chk({name, "_frame_err"}, longint'(frame_err), 0);
    chk({name, "_timeout"}, longint'(timeout), 0);
    chk({name, "_byte_cnt"}, longint'(byte_cnt), 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b1;
    tick(2);

    // full packet: 0x00, 0x0A, ... 0xBE
    exp_pkt = 1;
    do_arm();
    chk("full_busy_armed", longint'(busy), 1);
    tick(CPB * 30);
    for (int i = 0; i < PKT_LEN; i++) begin
      expect_wr(i, 8'(i * 10));
      send_byte(8'(i * 10), 1'b1, (i == PKT_LEN - 1) ? 0 : 10);
    end
    wait_quiet("full", 200);
    chk("full_busy_after", longint'(busy), 0);
    chk("full_byte_cnt", longint'(byte_cnt), PKT_LEN);

    // start glitch, then a real byte
    do_arm();
    tick(5);
    UART_RX = 1'b0;
    tick(8);
    UART_RX = 1'b1;
    tick(60);
    chk("glitch_busy", longint'(busy), 1);
    chk("glitch_byte_cnt", longint'(byte_cnt), 0);
    expect_wr(0, 8'h5A);
    send_byte(8'h5A, 1'b1, 1);
    wait_quiet("glitch", 100);
    chk("glitch_after_cnt", longint'(byte_cnt), 1);

    // frame error on byte 5
    do_arm();
    for (int i = 0; i < 5; i++) begin
      expect_wr(i, 8'(8'h30 + i));
      send_byte(8'(8'h30 + i), 1'b1, 1);
    end
    send_byte(8'hC3, 1'b0, 1);
    wait_quiet("ferr", 100);
    chk("ferr_flag", longint'(frame_err), 1);
    chk("ferr_busy", longint'(busy), 0);
    chk("ferr_byte_cnt", longint'(byte_cnt), 5);
    do_arm();
    chk("ferr_cleared", longint'(frame_err), 0);
    chk("ferr_rearm_busy", longint'(busy), 1);

    // timeout after 7 bytes
    exp_tmo = 1;
    exp_tmo_bytes = 7;
    do_arm();
    for (int i = 0; i < 7; i++) begin
      expect_wr(i, 8'(8'hE1 - i));
      send_byte(8'(8'hE1 - i), 1'b1, 1);
    end
    wait_quiet("timeout", TMO + 400);
    chk("timeout_busy", longint'(busy), 0);
    chk("timeout_byte_cnt", longint'(byte_cnt), 7);

    // re-arm during byte 12
    do_arm();
    for (int i = 0; i < 11; i++) begin
      expect_wr(i, 8'(8'hA0 + i));
      send_byte(8'(8'hA0 + i), 1'b1, 1);
    end
    UART_RX = 1'b0;
    tick(CPB);
    UART_RX = 1'b1;
    tick(CPB * 3);
    do_arm();
    chk("rearm_byte_cnt", longint'(byte_cnt), 0);
    chk("rearm_busy", longint'(busy), 1);
    tick(CPB * 2);
    expect_wr(0, 8'h77);
    send_byte(8'h77, 1'b1, 1);
    wait_quiet("rearm", 100);
    chk("rearm_after_cnt", longint'(byte_cnt), 1);

    // reset mid-DATA, then a clean packet
    do_arm();
    expect_wr(0, 8'h11);
    send_byte(8'h11, 1'b1, 1);
    UART_RX = 1'b0;
    tick(CPB * 3);
    chk("pre_reset_busy", longint'(busy), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    UART_RX = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("post_reset_no_write", exp_q.size(), 0);
    exp_pkt = 1;
    do_arm();
    for (int i = 0; i < PKT_LEN; i++) begin
      expect_wr(i, 8'(i * 13 + 7));
      send_byte(8'(i * 13 + 7), 1'b1, 1);
    end
    wait_quiet("post_reset", 200);
    chk("post_reset_busy", longint'(busy), 0);
    chk("post_reset_cnt", longint'(byte_cnt), PKT_LEN);

    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
